spu_mem_responder: RTL and testbench
====================================

// Module: spu_mem_responder
// PURPOSE
// - Serves the per-voice-slot SPU RAM access codes (NO_SPU_READ, VOICE_RD, VOICE_WR, FIFO_RD,
//   FIFO_WRITE from spu_def.sv) issued by the voice-state sequencer.
// - Runs the request/ack handshake toward the SPU RAM controller.
// - Returns read data on o_dataInRAM early enough for the sequencer's fixed sampling slot.
// - Sits between the voice/reverb sequencing logic and the external SPU RAM port.
// PARAMETERS
// - ADR_W        18  halfword address width (512 KiB SPU RAM)
// - SLOT_LATENCY  4  max cycles from accepted read code to o_dataValid (deadline)
// PORTS
// - i_clk            in   1      clock; single clock domain
// - i_rst            in   1      synchronous reset, active-high
// - i_SPUMemWRSel    in   3      access code; sampled every cycle
// - i_voiceAdr       in   ADR_W  address for VOICE_RD / VOICE_WR
// - i_fifoAdr        in   ADR_W  address for FIFO_RD / FIFO_WRITE
// - i_voiceWrData    in   16     write data for VOICE_WR
// - i_fifoWrData     in   16     write data for FIFO_WRITE
// - o_memAdr         out  ADR_W  address to RAM controller
// - o_memRd          out  1      read request; held until i_memAck
// - o_memWr          out  1      write request; held until i_memAck
// - o_memWrData      out  16     write data; stable while o_memWr=1
// - i_memAck         in   1      request accepted (write complete)
// - i_memRdValid     in   1      read data valid (>=1 cycle after ack)
// - i_memRdData      in   16     read data
// - o_dataInRAM      out  16     last read data; held until next read completes
// - o_dataValid      out  1      1-cycle pulse when o_dataInRAM updates
// - o_fifoRdPush     out  1      1-cycle pulse; read data belongs to a FIFO_RD
// - o_busy           out  1      state != IDLE
// - o_collision      out  1      1-cycle pulse; non-NO_SPU_READ code dropped while busy
// - o_lateErr        out  1      1-cycle pulse; read missed SLOT_LATENCY deadline
// BEHAVIOUR
// - Reset: state=IDLE; all o_* = 0; o_dataInRAM = 16'h0; deadline counter = 0.
// - FSM states: IDLE, REQ, WAITRD.
// - IDLE, code != NO_SPU_READ: register address, data and kind; go to REQ. o_memRd or o_memWr
//   rises on the next cycle. Address mux: VOICE_* -> i_voiceAdr; FIFO_* -> i_fifoAdr.
// - REQ: hold the request and o_memAdr/o_memWrData constant until i_memAck.
//   - Write + ack: drop o_memWr on the next cycle; go to IDLE.
//   - Read + ack: drop o_memRd on the next cycle; go to WAITRD.
// - WAITRD, i_memRdValid: on the next edge, o_dataInRAM <= i_memRdData and o_dataValid=1.
//   o_fifoRdPush=1 if the kind is FIFO_RD. Go to IDLE.
// - i_memRdValid outside WAITRD: ignored. This includes a stale return after reset.
// - Only one access is in flight. A code != NO_SPU_READ while not IDLE is dropped and pulses
//   o_collision. An access completing this cycle still counts as busy: back-to-back codes need
//   one IDLE cycle between them.
// - Deadline counter: cleared on read accept; +1 per cycle in REQ/WAITRD; saturates at
//   SLOT_LATENCY+1.
//   - If data has not returned by count==SLOT_LATENCY: pulse o_lateErr once. The transaction
//     still completes normally.
//   - Data returned exactly at count SLOT_LATENCY: o_lateErr stays 0.
// - Reset mid-operation: requests drop on the reset edge; o_dataInRAM is cleared.
// - Widths: addresses are passed through unmodified, no wrap logic. The controller owns wrap
//   at 2^ADR_W.
// CONFIGURATION
// - SPU_MEMRESP_LATECHK_EN defined: the deadline counter is instantiated and o_lateErr is
//   driven as above.
// - Not defined: no counter is instantiated and o_lateErr is tied to 0. All other behaviour
//   is identical.
// TESTING
// - VOICE_RD, i_voiceAdr=18'h01234. Controller acks next cycle and returns 16'h0403 one cycle
//   later -> o_memAdr=18'h01234; o_dataInRAM=16'h0403 with o_dataValid pulse within 4 cycles;
//   o_lateErr=0.
// - FIFO_WRITE, i_fifoAdr=18'h3FFFF, i_fifoWrData=16'hBEEF. Ack delayed 3 cycles ->
//   o_memWr/o_memWrData stable for all 3 cycles; o_busy=0 one cycle after ack; o_dataInRAM
//   unchanged.
// - FIFO_RD returning 16'hA5A5 -> o_fifoRdPush and o_dataValid pulse in the same cycle.
//   A following VOICE_RD -> o_fifoRdPush=0.
// - VOICE_WR issued while WAITRD -> o_collision=1 for 1 cycle; no o_memWr; the pending read
//   completes normally.
// - LATECHK_EN defined: read data returned at count 6 -> o_lateErr pulses once at count 4,
//   and o_dataInRAM updates at 6. Same test with the macro undefined -> o_lateErr=0.
// - i_rst asserted while o_memRd=1 -> next cycle o_memRd=0, o_dataInRAM=0; a later
//   i_memRdValid produces no o_dataValid.

Source files
------------

// File: rtl/spu_mem_responder.sv
// spu_mem_responder: serves per-voice-slot SPU RAM access codes from the
// voice-state sequencer and runs the req/ack handshake toward the SPU RAM
// controller. One access in flight; codes arriving while busy are dropped
// and flagged on o_collision.
// Optional: define SPU_MEMRESP_LATECHK_EN to build the read deadline counter
// that drives o_lateErr; without it o_lateErr is tied low.
module spu_mem_responder #(
  parameter int ADR_W        = 18,
  parameter int SLOT_LATENCY = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [2:0]       i_SPUMemWRSel,
  input  logic [ADR_W-1:0] i_voiceAdr,
  input  logic [ADR_W-1:0] i_fifoAdr,
  input  logic [15:0]      i_voiceWrData,
  input  logic [15:0]      i_fifoWrData,
  output logic [ADR_W-1:0] o_memAdr,
  output logic             o_memRd,
  output logic             o_memWr,
  output logic [15:0]      o_memWrData,
  input  logic             i_memAck,
  input  logic             i_memRdValid,
  input  logic [15:0]      i_memRdData,
  output logic [15:0]      o_dataInRAM,
  output logic             o_dataValid,
  output logic             o_fifoRdPush,
  output logic             o_busy,
  output logic             o_collision,
  output logic             o_lateErr
);

  // Access codes shared with the voice-state sequencer
  localparam logic [2:0] NO_SPU_READ = 3'd0;
  localparam logic [2:0] VOICE_RD    = 3'd1;
  localparam logic [2:0] VOICE_WR    = 3'd2;
  localparam logic [2:0] FIFO_RD     = 3'd3;
  localparam logic [2:0] FIFO_WRITE  = 3'd4;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] REQ    = 2'd1;
  localparam logic [1:0] WAITRD = 2'd2;

  logic [1:0] state;
  logic       isRead;
  logic       isFifo;

  // Code decode; unknown codes are treated like NO_SPU_READ
  logic codeValid, codeRead, codeFifo;
  always_comb begin
    codeRead  = (i_SPUMemWRSel == VOICE_RD) || (i_SPUMemWRSel == FIFO_RD);
    codeFifo  = (i_SPUMemWRSel == FIFO_RD)  || (i_SPUMemWRSel == FIFO_WRITE);
    codeValid = codeRead || (i_SPUMemWRSel == VOICE_WR) || (i_SPUMemWRSel == FIFO_WRITE);
  end

  assign o_busy = (state != IDLE);

  // Access FSM: latch request in IDLE, hold until ack, wait for read data
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= IDLE;
      isRead       <= 1'b0;
      isFifo       <= 1'b0;
      o_memAdr     <= '0;
      o_memWrData  <= 16'h0;
      o_memRd      <= 1'b0;
      o_memWr      <= 1'b0;
      o_dataInRAM  <= 16'h0;
      o_dataValid  <= 1'b0;
      o_fifoRdPush <= 1'b0;
      o_collision  <= 1'b0;
    end else begin
      o_dataValid  <= 1'b0;
      o_fifoRdPush <= 1'b0;
      // a completing access still occupies its slot, so this also flags
      // a code that lands on the ack / data-return cycle
      o_collision  <= (state != IDLE) && codeValid;
      case (state)
        IDLE: if (codeValid) begin
          o_memAdr    <= codeFifo ? i_fifoAdr    : i_voiceAdr;
          o_memWrData <= codeFifo ? i_fifoWrData : i_voiceWrData;
          isRead      <= codeRead;
          isFifo      <= codeFifo;
          o_memRd     <= codeRead;
          o_memWr     <= !codeRead;
          state       <= REQ;
        end
        REQ: if (i_memAck) begin
          o_memRd <= 1'b0;
          o_memWr <= 1'b0;
          state   <= isRead ? WAITRD : IDLE;
        end
        WAITRD: if (i_memRdValid) begin
          o_dataInRAM  <= i_memRdData;
          o_dataValid  <= 1'b1;
          o_fifoRdPush <= isFifo;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPU_MEMRESP_LATECHK_EN
  localparam int CNT_W = $clog2(SLOT_LATENCY + 2);
  localparam logic [CNT_W-1:0] CNT_DL  = CNT_W'(SLOT_LATENCY);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(SLOT_LATENCY + 1);

  logic [CNT_W-1:0] lateCnt;

  // Deadline counter: zero on read accept, counts busy cycles, saturates
  // one past the deadline so the error can only fire once per access
  always_ff @(posedge i_clk) begin
    if (i_rst)
      lateCnt <= '0;
    else if (state == IDLE && codeRead)
      lateCnt <= '0;
    else if (state != IDLE && lateCnt != CNT_SAT)
      lateCnt <= lateCnt + 1'b1;
  end

  // Flag in the deadline cycle itself unless the data arrives right then
  assign o_lateErr = isRead && (state != IDLE) && (lateCnt == CNT_DL) &&
                     !(state == WAITRD && i_memRdValid);
`else
  assign o_lateErr = 1'b0;
`endif

endmodule

// File: tb/tb_spu_mem_responder.sv
// Self-checking bench for spu_mem_responder: directed scenarios plus
// randomized accesses checked against a transaction-level model.
module tb_spu_mem_responder;

  localparam int ADR_W    = 18;
  localparam int SLOT_LAT = 4;
`ifdef SPU_MEMRESP_LATECHK_EN
  localparam bit LATE_EN = 1'b1;
`else
  localparam bit LATE_EN = 1'b0;
`endif

  localparam logic [2:0] NO_SPU_READ = 3'd0;
  localparam logic [2:0] VOICE_RD    = 3'd1;
  localparam logic [2:0] VOICE_WR    = 3'd2;
  localparam logic [2:0] FIFO_RD     = 3'd3;
  localparam logic [2:0] FIFO_WRITE  = 3'd4;

  logic             clk = 1'b0;
  logic             rst;
  logic [2:0]       code;
  logic [ADR_W-1:0] voiceAdr, fifoAdr, memAdr;
  logic [15:0]      voiceWrData, fifoWrData, memWrData, memRdData, dataInRAM;
  logic             memRd, memWr, memAck, memRdValid;
  logic             dataValid, fifoRdPush, busy, collision, lateErr;

  int nTests = 0;
  int nFail  = 0;
  logic [15:0] expData = 16'h0;

  always #5 clk = ~clk;

  spu_mem_responder #(.ADR_W(ADR_W), .SLOT_LATENCY(SLOT_LAT)) dut (
    .i_clk(clk), .i_rst(rst), .i_SPUMemWRSel(code),
    .i_voiceAdr(voiceAdr), .i_fifoAdr(fifoAdr),
    .i_voiceWrData(voiceWrData), .i_fifoWrData(fifoWrData),
    .o_memAdr(memAdr), .o_memRd(memRd), .o_memWr(memWr), .o_memWrData(memWrData),
    .i_memAck(memAck), .i_memRdValid(memRdValid), .i_memRdData(memRdData),
    .o_dataInRAM(dataInRAM), .o_dataValid(dataValid), .o_fifoRdPush(fifoRdPush),
    .o_busy(busy), .o_collision(collision), .o_lateErr(lateErr)
  );

  // advance one clock; land on the falling edge to drive next inputs
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; code = NO_SPU_READ; memAck = 1'b0; memRdValid = 1'b0;
    voiceAdr = '0; fifoAdr = '0; voiceWrData = '0; fifoWrData = '0; memRdData = '0;
    cyc(); cyc();
    rst = 1'b0;
    #1;
    nTests++;
    if ({memRd, memWr, dataValid, fifoRdPush, busy, collision, lateErr} !== 7'b0 ||
        memAdr !== '0 || memWrData !== 16'h0 || dataInRAM !== 16'h0) begin
      nFail++;
      $display("FAIL reset: rd=%b wr=%b dv=%b push=%b busy=%b col=%b late=%b adr=%h wd=%h data=%h, all must be 0",
               memRd, memWr, dataValid, fifoRdPush, busy, collision, lateErr, memAdr, memWrData, dataInRAM);
    end
  endtask

  // One complete access. Model: the request must be held for ackDly+1
  // cycles; read data returned at deadline count ackDly+1+rdDly; a return
  // later than SLOT_LAT produces exactly one lateErr, in cycle SLOT_LAT.
  task automatic doAccess(input logic [2:0] c, input logic [ADR_W-1:0] adr,
                          input logic [15:0] wd, input int ackDly, input int rdDly,
                          input logic [15:0] rd, input string name);
    bit isRd, isF;
    int lateSeen, lateAt, retCnt, expLate, idx;
    isRd = (c == VOICE_RD) || (c == FIFO_RD);
    isF  = (c == FIFO_RD) || (c == FIFO_WRITE);
    retCnt = ackDly + 1 + rdDly;
    expLate = (LATE_EN && isRd && retCnt > SLOT_LAT) ? 1 : 0;
    lateSeen = 0; lateAt = -1; idx = 0;
    if (isF) begin
      fifoAdr = adr; fifoWrData = wd;
      voiceAdr = ADR_W'($urandom); voiceWrData = 16'($urandom);
    end else begin
      voiceAdr = adr; voiceWrData = wd;
      fifoAdr = ADR_W'($urandom); fifoWrData = 16'($urandom);
    end
    code = c;
    cyc();
    code = NO_SPU_READ;
    for (int k = 0; k <= ackDly; k++) begin
      memAck = (k == ackDly);
      voiceAdr = ADR_W'($urandom); fifoAdr = ADR_W'($urandom);
      voiceWrData = 16'($urandom); fifoWrData = 16'($urandom);
      #1;
      nTests++;
      if (memRd !== isRd || memWr !== !isRd || memAdr !== adr ||
          (!isRd && memWrData !== wd) || busy !== 1'b1) begin
        nFail++;
        $display("FAIL %s req_hold[%0d]: rd=%b wr=%b adr=%h wd=%h busy=%b, want rd=%b wr=%b adr=%h wd=%h busy=1",
                 name, k, memRd, memWr, memAdr, memWrData, busy, isRd, !isRd, adr, wd);
      end
      if (lateErr === 1'b1) begin lateSeen++; if (lateAt < 0) lateAt = idx; end
      idx++;
      cyc();
    end
    memAck = 1'b0;
    if (!isRd) begin
      #1;
      nTests++;
      if (memWr !== 1'b0 || busy !== 1'b0 || dataValid !== 1'b0 || dataInRAM !== expData || lateErr !== 1'b0) begin
        nFail++;
        $display("FAIL %s wr_done: wr=%b busy=%b dv=%b data=%h late=%b, want 0 0 0 %h 0",
                 name, memWr, busy, dataValid, dataInRAM, lateErr, expData);
      end
      cyc();
      return;
    end
    for (int j = 0; j <= rdDly; j++) begin
      memRdValid = (j == rdDly);
      memRdData  = (j == rdDly) ? rd : 16'($urandom);
      #1;
      nTests++;
      if (memRd !== 1'b0 || busy !== 1'b1 || dataValid !== 1'b0) begin
        nFail++;
        $display("FAIL %s wait_rd[%0d]: rd=%b busy=%b dv=%b, want 0 1 0", name, j, memRd, busy, dataValid);
      end
      if (lateErr === 1'b1) begin lateSeen++; if (lateAt < 0) lateAt = idx; end
      idx++;
      cyc();
    end
    memRdValid = 1'b0;
    memRdData  = 16'($urandom);
    #1;
    expData = rd;
    nTests++;
    if (dataValid !== 1'b1 || dataInRAM !== rd || fifoRdPush !== isF || busy !== 1'b0) begin
      nFail++;
      $display("FAIL %s rd_done: dv=%b data=%h push=%b busy=%b, want 1 %h %b 0",
               name, dataValid, dataInRAM, fifoRdPush, busy, rd, isF);
    end
    if (lateErr === 1'b1) begin lateSeen++; if (lateAt < 0) lateAt = idx; end
    nTests++;
    if (lateSeen != expLate || (expLate == 1 && lateAt != SLOT_LAT)) begin
      nFail++;
      $display("FAIL %s late_err: pulses=%0d at=%0d, want pulses=%0d at=%0d (return count %0d)",
               name, lateSeen, lateAt, expLate, SLOT_LAT, retCnt);
    end
    cyc();
    #1;
    nTests++;
    if (dataValid !== 1'b0 || fifoRdPush !== 1'b0 || dataInRAM !== rd) begin
      nFail++;
      $display("FAIL %s pulse_end: dv=%b push=%b data=%h, want 0 0 %h", name, dataValid, fifoRdPush, dataInRAM, rd);
    end
  endtask

  task automatic test_directed();
    doAccess(VOICE_RD,   18'h01234, 16'h0,    0, 0, 16'h0403, "voice_rd");
    doAccess(FIFO_WRITE, 18'h3FFFF, 16'hBEEF, 3, 0, 16'h0,    "fifo_wr");
    doAccess(FIFO_RD,    18'h00010, 16'h0,    1, 1, 16'hA5A5, "fifo_rd");
    doAccess(VOICE_RD,   18'h20000, 16'h0,    0, 1, 16'h5A5A, "voice_rd2");
    doAccess(VOICE_WR,   18'h00FFF, 16'h1234, 0, 0, 16'h0,    "voice_wr");
  endtask

  task automatic test_deadline();
    doAccess(VOICE_RD, 18'h00ABC, 16'h0, 0, 5, 16'hC0DE, "late6");
    doAccess(FIFO_RD,  18'h00ABD, 16'h0, 0, 3, 16'hCAFE, "ontime4");
    doAccess(VOICE_RD, 18'h00ABE, 16'h0, 2, 3, 16'hF00D, "late6_ack");
  endtask

  task automatic test_collision();
    // voice write landing while a read waits for data
    voiceAdr = 18'h00111; code = VOICE_RD;
    cyc();
    code = NO_SPU_READ; memAck = 1'b1;
    cyc();
    memAck = 1'b0; code = VOICE_WR; voiceAdr = 18'h00222; voiceWrData = 16'h7777;
    cyc();
    code = NO_SPU_READ;
    #1;
    nTests++;
    if (collision !== 1'b1 || memWr !== 1'b0 || busy !== 1'b1) begin
      nFail++;
      $display("FAIL collision_pulse: col=%b wr=%b busy=%b, want 1 0 1", collision, memWr, busy);
    end
    cyc();
    memRdValid = 1'b1; memRdData = 16'h1357;
    #1;
    nTests++;
    if (collision !== 1'b0 || memWr !== 1'b0) begin
      nFail++;
      $display("FAIL collision_once: col=%b wr=%b, want 0 0", collision, memWr);
    end
    cyc();
    memRdValid = 1'b0;
    #1;
    expData = 16'h1357;
    nTests++;
    if (dataValid !== 1'b1 || dataInRAM !== 16'h1357 || busy !== 1'b0) begin
      nFail++;
      $display("FAIL collision_rd_done: dv=%b data=%h busy=%b, want 1 1357 0", dataValid, dataInRAM, busy);
    end
    cyc();
    // code on the ack cycle of a write is still a collision
    fifoAdr = 18'h00333; fifoWrData = 16'h4444; code = FIFO_WRITE;
    cyc();
    code = VOICE_RD; memAck = 1'b1;
    cyc();
    code = NO_SPU_READ; memAck = 1'b0;
    #1;
    nTests++;
    if (collision !== 1'b1 || busy !== 1'b0 || memRd !== 1'b0 || memWr !== 1'b0) begin
      nFail++;
      $display("FAIL back_to_back: col=%b busy=%b rd=%b wr=%b, want 1 0 0 0", collision, busy, memRd, memWr);
    end
    cyc();
    #1;
    nTests++;
    if (collision !== 1'b0 || busy !== 1'b0 || memRd !== 1'b0) begin
      nFail++;
      $display("FAIL back_to_back_drop: col=%b busy=%b rd=%b, want 0 0 0", collision, busy, memRd);
    end
  endtask

  task automatic test_reset_mid();
    voiceAdr = 18'h01111; code = VOICE_RD;
    cyc();
    code = NO_SPU_READ;
    #1;
    nTests++;
    if (memRd !== 1'b1 || dataInRAM !== expData) begin
      nFail++;
      $display("FAIL rst_mid_pre: rd=%b data=%h, want 1 %h", memRd, dataInRAM, expData);
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    expData = 16'h0;
    nTests++;
    if (memRd !== 1'b0 || dataInRAM !== 16'h0 || busy !== 1'b0) begin
      nFail++;
      $display("FAIL rst_mid: rd=%b data=%h busy=%b, want 0 0000 0", memRd, dataInRAM, busy);
    end
    memRdValid = 1'b1; memRdData = 16'hFFFF;
    cyc();
    memRdValid = 1'b0;
    #1;
    nTests++;
    if (dataValid !== 1'b0 || dataInRAM !== 16'h0) begin
      nFail++;
      $display("FAIL stale_rdvalid: dv=%b data=%h, want 0 0000", dataValid, dataInRAM);
    end
    cyc();
  endtask

  task automatic test_random();
    logic [2:0] codes [4];
    codes[0] = VOICE_RD; codes[1] = VOICE_WR; codes[2] = FIFO_RD; codes[3] = FIFO_WRITE;
    for (int n = 0; n < 30; n++)
      doAccess(codes[$urandom_range(0, 3)], ADR_W'($urandom), 16'($urandom),
               $urandom_range(0, 3), $urandom_range(0, 4), 16'($urandom), "random");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_deadline();
    test_collision();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
